mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1: 1 = memory states wait on mem_ready; 0 = memory always single-cycle, mem_ready ignored.
REQ-002 Parameter TIMEOUT, default 16, range 1..255: maximum wait cycles per memory access before fault.
REQ-003 Parameter EXT_OPS, default 1: 1 = lui/auipc/jalr decoded; 0 = those opcodes treated as illegal.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 opcode  in  7  instruction opcode from IR.
REQ-008 funct3  in  3  instruction funct3 from IR.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
REQ-011 ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-012 ALUOp  out  2  00 add, 01 compare/sub, 10 funct decode.
REQ-013 ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result.
REQ-014 IRWrite, PCUpdate, RegWrite, MemWrite, AddrSrc, Branch  out  1 each  control strobes.
REQ-015 BranchType  out  3  equals funct3 while Branch=1, else 000.
REQ-016 illegal  out  1  one-cycle pulse on unsupported instruction.
REQ-017 fault  out  1  sticky memory-timeout indication.
REQ-018 state_o  out  4  current state encoding for debug.

Function
REQ-019 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, JAL, JALR, BRANCH, LUI, AUIPC, FAULT; Moore outputs decoded from state only, except where a strobe is stated as gated by mem_ready.
REQ-020 Unlisted outputs in any state SHALL be 0/00; no output holds its previous value.
REQ-021 FETCH: A=00, B=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready (or 1 when MEM_HANDSHAKE=0); advance to DECODE when strobes fire, else stay.
REQ-022 DECODE: A=01, B=01, ALUOp=00; next: 0000011/0100011->MEMADR, 0110011->EXER, 0010011->EXEI, 1101111->JAL, 1100111->JALR, 1100011->BRANCH, 0110111->LUI, 0010111->AUIPC.
REQ-023 DECODE with unsupported opcode, or branch funct3 010/011, or EXT_OPS=0 with ext opcode: illegal=1 for that cycle, next FETCH.
REQ-024 MEMADR: A=10, B=01, ALUOp=00; load->MEMRD, store->MEMWR.
REQ-025 MEMRD: AddrSrc=1, ResultSrc=00; advance to MEMWB on mem_ready, else stay.
REQ-026 MEMWR: AddrSrc=1, ResultSrc=00, MemWrite=1 held for the whole access; advance to FETCH on mem_ready.
REQ-027 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-028 EXER: A=10, B=00, ALUOp=10; EXEI: A=10, B=01, ALUOp=10; both -> ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-030 JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next ALUWB.
REQ-031 JALR: A=10, B=01, ALUOp=00 (ALUOut=rs1+imm); next JAL (reuses JAL for PC update and link).
REQ-032 BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00, Branch=1; next FETCH.
REQ-033 LUI: A=11, B=01, ALUOp=00; AUIPC: A=01, B=01, ALUOp=00; both -> ALUWB.
REQ-034 Wait counter, 8 bits: cleared on entering FETCH/MEMRD/MEMWR and on completion; increments each cycle those states wait with mem_ready=0.
REQ-035 Counter reaching TIMEOUT with mem_ready=0 -> FAULT next cycle; mem_ready=1 in that same cycle wins (normal completion).
REQ-036 FAULT: all strobes 0, fault=1, stays until reset.
REQ-037 MEM_HANDSHAKE=0: counter held 0, no waits, FAULT unreachable.

Reset
REQ-038 Reset sampled high: next state FETCH, counter 0, fault 0.
REQ-039 While reset is high, IRWrite, PCUpdate, RegWrite, MemWrite, illegal forced 0 regardless of state.
REQ-040 Reset mid-access (any state, including FAULT) aborts it with no further strobes.

Verification
REQ-041 add (0110011), mem_ready=1: FETCH,DECODE,EXER,ALUWB,FETCH; RegWrite=1 exactly in ALUWB.
REQ-042 lw, mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1.
REQ-043 sw, TIMEOUT=4, mem_ready stuck 0: MemWrite=1 for 4 cycles, then FAULT, fault=1 until reset.
REQ-044 jalr: FETCH,DECODE,JALR,JAL,ALUWB; PCUpdate=1 in JAL only beyond FETCH.
REQ-045 opcode 1111111: illegal=1 one cycle in DECODE, next FETCH; beq funct3=000: Branch=1, BranchType=000, ALUOp=01.
REQ-046 reset asserted in MEMWR with mem_ready=0: MemWrite=0 that cycle, state FETCH next, fault=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control unit with memory handshake, timeout fault and illegal-op detection
// clk/reset: rising-edge clock, synchronous active-high reset
// opcode/funct3: instruction fields from IR; mem_ready: memory access completes this cycle
// ALUSrcA/ALUSrcB/ALUOp/ResultSrc: datapath muxes; IRWrite/PCUpdate/RegWrite/MemWrite/AddrSrc/Branch: strobes
// BranchType: funct3 while branching; illegal: decode pulse; fault: sticky timeout; state_o: debug state
module mc_control_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT = 16,
  parameter int EXT_OPS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AddrSrc,
  output logic       Branch,
  output logic [2:0] BranchType,
  output logic       illegal,
  output logic       fault,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXER, S_EXEI,
    S_ALUWB, S_JAL, S_JALR, S_BRANCH, S_LUI, S_AUIPC, S_FAULT
  } state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic done, expired, ir_w, pc_u, reg_w, mem_w, ill;
  assign done = (MEM_HANDSHAKE == 0) || mem_ready;
  assign cnt_inc = cnt_q + 8'd1;
  // the cycle whose wait would bring the counter to TIMEOUT is the last one allowed
  assign expired = !done && (cnt_inc == TO);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    ResultSrc = 2'b00;
    ir_w = 1'b0;
    pc_u = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    AddrSrc = 1'b0;
    Branch = 1'b0;
    ill = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        ir_w = done;
        pc_u = done;
        state_d = done ? S_DECODE : expired ? S_FAULT : S_FETCH;
        cnt_d = (done || expired) ? 8'd0 : cnt_inc;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_FETCH;
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXER;
          7'b0010011: state_d = S_EXEI;
          7'b1101111: state_d = S_JAL;
          7'b1100111: state_d = (EXT_OPS != 0) ? S_JALR : S_FETCH;
          7'b1100011: state_d = (funct3[2:1] != 2'b01) ? S_BRANCH : S_FETCH;
          7'b0110111: state_d = (EXT_OPS != 0) ? S_LUI : S_FETCH;
          7'b0010111: state_d = (EXT_OPS != 0) ? S_AUIPC : S_FETCH;
          default: ;
        endcase
        ill = (state_d == S_FETCH);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        AddrSrc = 1'b1;
        state_d = done ? S_MEMWB : expired ? S_FAULT : S_MEMRD;
        cnt_d = (done || expired) ? 8'd0 : cnt_inc;
      end
      S_MEMWR: begin
        AddrSrc = 1'b1;
        mem_w = 1'b1;
        state_d = done ? S_FETCH : expired ? S_FAULT : S_MEMWR;
        cnt_d = (done || expired) ? 8'd0 : cnt_inc;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = 1'b1;
        state_d = S_FETCH;
      end
      S_EXER: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_u = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b01;
        Branch = 1'b1;
        state_d = S_FETCH;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end
  assign IRWrite = ir_w & ~reset;
  assign PCUpdate = pc_u & ~reset;
  assign RegWrite = reg_w & ~reset;
  assign MemWrite = mem_w & ~reset;
  assign illegal = ill & ~reset;
  assign BranchType = Branch ? funct3 : 3'b000;
  assign fault = (state_q == S_FAULT);
  assign state_o = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed checks of mc_control_fsm sequencing, strobes, timeout and reset
module tb_mc_control_fsm;
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXER = 4'd6, ALUWB = 4'd8, JAL = 4'd9, JALR = 4'd10, BRANCH = 4'd11,
    LUI = 4'd12, FAULT = 4'd14;
  logic clk = 1'b0;
  logic reset, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic ir_write, pc_update, reg_write, mem_write, addr_src, branch, illegal, fault;
  logic [2:0] branch_type;
  logic [3:0] state_o;
  int checks = 0;
  int failures = 0;
  mc_control_fsm #(.MEM_HANDSHAKE(1), .TIMEOUT(4), .EXT_OPS(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op), .ResultSrc(result_src),
    .IRWrite(ir_write), .PCUpdate(pc_update), .RegWrite(reg_write), .MemWrite(mem_write),
    .AddrSrc(addr_src), .Branch(branch), .BranchType(branch_type), .illegal(illegal),
    .fault(fault), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 7'b0110011;
    funct3 = 3'b000;
    tick();
    tick();
    chk("rst_state", 8'(state_o), 8'(FETCH));
    chk("rst_fault", 8'(fault), 8'd0);
    chk("rst_irwrite_forced", 8'(ir_write), 8'd0);
    chk("rst_pcupdate_forced", 8'(pc_update), 8'd0);
    reset = 1'b0;
    #1;
    chk("fetch_irwrite", 8'(ir_write), 8'd1);
    chk("fetch_pcupdate", 8'(pc_update), 8'd1);
    chk("fetch_srcb", 8'(alu_src_b), 8'd2);
    chk("fetch_result", 8'(result_src), 8'd2);
    tick();
    chk("add_decode", 8'(state_o), 8'(DECODE));
    chk("add_decode_srca", 8'(alu_src_a), 8'd1);
    chk("add_decode_regwrite", 8'(reg_write), 8'd0);
    tick();
    chk("add_exer", 8'(state_o), 8'(EXER));
    chk("add_exer_aluop", 8'(alu_op), 8'd2);
    chk("add_exer_srca", 8'(alu_src_a), 8'd2);
    chk("add_exer_regwrite", 8'(reg_write), 8'd0);
    tick();
    chk("add_aluwb", 8'(state_o), 8'(ALUWB));
    chk("add_aluwb_regwrite", 8'(reg_write), 8'd1);
    chk("add_aluwb_result", 8'(result_src), 8'd0);
    tick();
    chk("add_back_fetch", 8'(state_o), 8'(FETCH));
    chk("add_fetch_regwrite", 8'(reg_write), 8'd0);
    mem_ready = 1'b0;
    #1;
    chk("fetch_wait_irwrite", 8'(ir_write), 8'd0);
    tick();
    chk("fetch_wait_state", 8'(state_o), 8'(FETCH));
    mem_ready = 1'b1;
    opcode = 7'b0000011;
    tick();
    tick();
    chk("lw_memadr", 8'(state_o), 8'(MEMADR));
    chk("lw_memadr_srca", 8'(alu_src_a), 8'd2);
    chk("lw_memadr_srcb", 8'(alu_src_b), 8'd1);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_memrd_wait", 8'(state_o), 8'(MEMRD));
      chk("lw_memrd_addrsrc", 8'(addr_src), 8'd1);
      tick();
    end
    mem_ready = 1'b1;
    chk("lw_memrd_last", 8'(state_o), 8'(MEMRD));
    chk("lw_memrd_regwrite", 8'(reg_write), 8'd0);
    tick();
    chk("lw_memwb", 8'(state_o), 8'(MEMWB));
    chk("lw_memwb_result", 8'(result_src), 8'd1);
    chk("lw_memwb_regwrite", 8'(reg_write), 8'd1);
    tick();
    chk("lw_back_fetch", 8'(state_o), 8'(FETCH));
    opcode = 7'b1100111;
    tick();
    tick();
    chk("jalr_state", 8'(state_o), 8'(JALR));
    chk("jalr_pcupdate", 8'(pc_update), 8'd0);
    chk("jalr_srca", 8'(alu_src_a), 8'd2);
    tick();
    chk("jal_state", 8'(state_o), 8'(JAL));
    chk("jal_pcupdate", 8'(pc_update), 8'd1);
    chk("jal_srcb", 8'(alu_src_b), 8'd2);
    tick();
    chk("jalr_aluwb", 8'(state_o), 8'(ALUWB));
    chk("jalr_aluwb_pcupdate", 8'(pc_update), 8'd0);
    tick();
    opcode = 7'b1111111;
    tick();
    chk("ill_decode", 8'(state_o), 8'(DECODE));
    chk("ill_pulse", 8'(illegal), 8'd1);
    tick();
    chk("ill_next_fetch", 8'(state_o), 8'(FETCH));
    chk("ill_cleared", 8'(illegal), 8'd0);
    opcode = 7'b1100011;
    funct3 = 3'b000;
    tick();
    chk("beq_decode_legal", 8'(illegal), 8'd0);
    tick();
    chk("beq_state", 8'(state_o), 8'(BRANCH));
    chk("beq_branch", 8'(branch), 8'd1);
    chk("beq_type", 8'(branch_type), 8'd0);
    chk("beq_aluop", 8'(alu_op), 8'd1);
    funct3 = 3'b100;
    #1;
    chk("blt_type", 8'(branch_type), 8'd4);
    tick();
    chk("beq_back_fetch", 8'(state_o), 8'(FETCH));
    chk("fetch_branchtype_zero", 8'(branch_type), 8'd0);
    funct3 = 3'b010;
    tick();
    chk("branch_f3_010_illegal", 8'(illegal), 8'd1);
    tick();
    chk("branch_f3_010_fetch", 8'(state_o), 8'(FETCH));
    opcode = 7'b0110111;
    tick();
    tick();
    chk("lui_state", 8'(state_o), 8'(LUI));
    chk("lui_srca", 8'(alu_src_a), 8'd3);
    tick();
    chk("lui_aluwb", 8'(state_o), 8'(ALUWB));
    tick();
    opcode = 7'b0100011;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sw_memwr_state", 8'(state_o), 8'(MEMWR));
      chk("sw_memwrite", 8'(mem_write), 8'd1);
      tick();
    end
    chk("sw_timeout_fault_state", 8'(state_o), 8'(FAULT));
    chk("sw_fault_flag", 8'(fault), 8'd1);
    chk("sw_fault_memwrite", 8'(mem_write), 8'd0);
    mem_ready = 1'b1;
    tick();
    chk("fault_sticky_state", 8'(state_o), 8'(FAULT));
    chk("fault_sticky_flag", 8'(fault), 8'd1);
    chk("fault_irwrite", 8'(ir_write), 8'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("fault_reset_state", 8'(state_o), 8'(FETCH));
    chk("fault_reset_flag", 8'(fault), 8'd0);
    tick();
    tick();
    chk("sw2_memadr", 8'(state_o), 8'(MEMADR));
    mem_ready = 1'b0;
    tick();
    chk("sw2_memwr", 8'(state_o), 8'(MEMWR));
    chk("sw2_memwrite", 8'(mem_write), 8'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_memwrite", 8'(mem_write), 8'd0);
    tick();
    reset = 1'b0;
    chk("rst_mid_state", 8'(state_o), 8'(FETCH));
    chk("rst_mid_fault", 8'(fault), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
